// File: rtl/uart_sim_fifo.sv
// Simulation UART: CPU stores queue in a TX FIFO drained one character every DRAIN_CYCLES clocks.
// Optional build macro UART_SIM_IRQ_EN adds the irq output and the IRQCFG register at offset 0x10.
module uart_sim_fifo #(
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
`ifdef UART_SIM_IRQ_EN
  output logic        irq,
`endif
  output logic        tx_valid,
  output logic [7:0]  tx_byte
);
  localparam int            AW         = $clog2(FIFO_DEPTH);
  localparam int            TW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int            LOAD_I     = DRAIN_CYCLES - 1;
  localparam logic [TW-1:0] TIMER_LOAD = LOAD_I[TW-1:0];
  localparam logic [AW:0]   DEPTH      = FIFO_DEPTH[AW:0];

  logic [31:0]   offset;
  logic          sel_txdata, sel_status, sel_ctrl, sel_txcount;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic [TW-1:0] timer;
  logic          timer_active, drain_en, overflow;
  logic [31:0]   txcount;
  logic          full, empty, push_req, push_ok, pop, flush, overflow_set;
  logic [7:0]    count_byte;
  logic [31:0]   status_word, rd_mux;
  logic          unused_bits;
`ifdef UART_SIM_IRQ_EN
  logic          sel_irqcfg, empty_ie, overflow_ie;
`endif

  assign offset      = address - BASE_ADDR;
  assign sel_txdata  = (offset == 32'h0);
  assign sel_status  = (offset == 32'h4);
  assign sel_ctrl    = (offset == 32'h8);
  assign sel_txcount = (offset == 32'hC);
`ifdef UART_SIM_IRQ_EN
  assign sel_irqcfg  = (offset == 32'h10);
`endif
  assign unused_bits = ^write_data[31:8];

  assign full         = (count == DEPTH);
  assign empty        = (count == '0);
  assign flush        = write_enable && sel_ctrl && write_data[1];
  // The timer only runs while entries exist, so reaching zero always has a head to pop.
  assign pop          = timer_active && drain_en && (timer == '0) && !flush;
  assign push_req     = write_enable && sel_txdata;
  assign push_ok      = push_req && (!full || pop);
  assign overflow_set = push_req && full && !pop;
  assign count_next   = flush ? '0
                      : count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};

  assign count_byte  = 8'(count);
  assign status_word = {16'h0, count_byte, 4'h0, overflow, timer_active, empty, full};

  always_comb begin
    rd_mux = 32'h0;
    if (sel_status)       rd_mux = status_word;
    else if (sel_ctrl)    rd_mux = {31'h0, drain_en};
    else if (sel_txcount) rd_mux = txcount;
`ifdef UART_SIM_IRQ_EN
    else if (sel_irqcfg)  rd_mux = {30'h0, overflow_ie, empty_ie};
`endif
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= write_data[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      timer        <= '0;
      timer_active <= 1'b0;
      drain_en     <= 1'b1;
      overflow     <= 1'b0;
      txcount      <= '0;
      read_data    <= '0;
      tx_valid     <= 1'b0;
      tx_byte      <= '0;
    end else begin
      count    <= count_next;
      tx_valid <= pop;
      if (read_enable) read_data <= rd_mux;

      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (flush)    rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + AW'(1);

      if (pop) begin
        tx_byte <= mem[rd_ptr];
`ifndef SYNTHESIS
        $write("%c", mem[rd_ptr]);
`endif
      end

      // drain_en low freezes the timer in place; re-enabling resumes without a reload.
      if (flush) begin
        timer_active <= 1'b0;
      end else if (timer_active) begin
        if (drain_en) begin
          if (timer != '0)            timer <= timer - TW'(1);
          else if (count_next != '0) timer <= TIMER_LOAD;
          else                       timer_active <= 1'b0;
        end
      end else if (drain_en && !empty) begin
        timer_active <= 1'b1;
        timer        <= TIMER_LOAD;
      end

      if (write_enable && sel_ctrl) drain_en <= write_data[0];

      if (overflow_set)                                      overflow <= 1'b1;
      else if (write_enable && sel_status && write_data[3]) overflow <= 1'b0;

      if (write_enable && sel_txcount) txcount <= '0;
      else if (pop)                    txcount <= txcount + 32'd1;
    end
  end

`ifdef UART_SIM_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      empty_ie    <= 1'b0;
      overflow_ie <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (write_enable && sel_irqcfg) begin
        empty_ie    <= write_data[0];
        overflow_ie <= write_data[1];
      end
      irq <= (empty_ie && empty) || (overflow_ie && overflow);
    end
  end
`endif

endmodule
